// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner bank: FSM state
// encoding, LED mode constants and a state-to-level helper.
package btn_pkg;

    // Bit 1 of the encoding is the debounced level, so STATE comes straight
    // from a state flop without any decode.
    typedef enum logic [1:0] {
        UP      = 2'b00,
        DN_PEND = 2'b01,
        DOWN    = 2'b10,
        UP_PEND = 2'b11
    } btn_state_e;

    localparam logic MODE_MOMENTARY = 1'b0;
    localparam logic MODE_TOGGLE    = 1'b1;

    function automatic logic state_level(input btn_state_e s);
        return s[1];
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce/long-press FSM with a
// single shared counter, and the LED drive register.
//
// Handshake note: this block has no valid/ready interfaces. PRESS, RELEASE
// and LONG are single-cycle strobes with no back-pressure; a consumer must
// sample them on the cycle they are high.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    input  logic MODE,
    output logic STATE,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic LED
);

    localparam int CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync0;
    logic             sync1;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             long_done;
    logic             led_q;

    assign STATE = state_level(state);
    assign LED   = led_q;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= BTN;
            sync1 <= sync0;
        end
    end

    // Debounce FSM; the counter measures stability while pending and hold
    // time while down. Pulses and the LED are registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= UP;
            cnt       <= '0;
            long_done <= 1'b0;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
            LONG      <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
            // Momentary mode tracks the level; accepted transitions below
            // override this with the new level in the same cycle.
            if (MODE == MODE_MOMENTARY) begin
                led_q <= state_level(state);
            end
            case (state)
                UP: begin
                    if (sync1) begin
                        state <= DN_PEND;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                DN_PEND: begin
                    if (!sync1) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (cnt == DEB_C) begin
                        state <= DOWN;
                        cnt   <= '0;
                        PRESS <= 1'b1;
                        led_q <= (MODE == MODE_TOGGLE) ? ~led_q : 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!sync1) begin
                        state <= UP_PEND;
                        cnt   <= CNT_ONE;
                    end else if (cnt != LONG_C) begin
                        cnt <= cnt + CNT_ONE;
                        if ((cnt == LONG_C - CNT_ONE) && !long_done) begin
                            LONG      <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end
                end
                UP_PEND: begin
                    // A bounce back to DOWN keeps the counter as is; long_done
                    // stays set so LONG cannot fire twice for one press.
                    if (sync1) begin
                        state <= DOWN;
                    end else if (cnt == DEB_C) begin
                        state     <= UP;
                        cnt       <= '0;
                        RELEASE   <= 1'b1;
                        long_done <= 1'b0;
                        if (MODE == MODE_MOMENTARY) begin
                            led_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of N_CH independent push-button conditioners. Each bus bit maps to
// one btn_debounce_ch instance; channels share nothing but clock and reset.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    input  logic [N_CH-1:0] MODE,
    output logic [N_CH-1:0] STATE,
    output logic [N_CH-1:0] PRESS,
    output logic [N_CH-1:0] RELEASE,
    output logic [N_CH-1:0] LONG,
    output logic [N_CH-1:0] LED
);

    // One conditioner per button pin.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .BTN     (BTN[i]),
            .MODE    (MODE[i]),
            .STATE   (STATE[i]),
            .PRESS   (PRESS[i]),
            .RELEASE (RELEASE[i]),
            .LONG    (LONG[i]),
            .LED     (LED[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Bench for btn_debounce_bank: directed scenarios followed by random button
// activity, all checked every cycle against a run-length reference model.
module tb_btn_debounce_bank;

    localparam int N_CH = 2;
    localparam int DEB  = 4;
    localparam int LNG  = 10;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    logic [N_CH-1:0] BTN, MODE, STATE, PRESS, RELEASE, LONG, LED;

    always #5 CLK = ~CLK;

    btn_debounce_bank #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN     (BTN),
        .MODE    (MODE),
        .STATE   (STATE),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .LONG    (LONG),
        .LED     (LED)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    // Level is accepted once DEB+1 consecutive synchronised samples differ
    // from it; hold time counts from the press (restarting on a release
    // attempt) and LONG fires once per press when it reaches LNG.
    logic [N_CH-1:0] m_s0, m_s1, m_lvl, m_press, m_rel, m_long, m_led, m_done;
    int m_run[N_CH];
    int m_t[N_CH];

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        m_long = '0; m_led = '0; m_done = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_run[c] = 0;
            m_t[c]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            logic samp;
            samp    = m_s1[c];
            m_s1[c] = m_s0[c];
            m_s0[c] = BTN[c];
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_long[c]  = 1'b0;
            if (!m_lvl[c]) begin
                if (samp) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_lvl[c] = 1'b1; m_run[c] = 0; m_t[c] = 0; m_press[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end else begin
                if (!samp) begin
                    m_run[c]++;
                    m_t[c] = (m_run[c] == 1) ? 1 : m_t[c] + 1;
                    if (m_run[c] == DEB + 1) begin
                        m_lvl[c] = 1'b0; m_run[c] = 0; m_rel[c] = 1'b1; m_done[c] = 1'b0;
                    end
                end else if (m_run[c] > 0) begin
                    m_run[c] = 0;
                end else if (m_t[c] < LNG) begin
                    m_t[c]++;
                    if (m_t[c] == LNG && !m_done[c]) begin
                        m_long[c] = 1'b1; m_done[c] = 1'b1;
                    end
                end
            end
            if (MODE[c]) begin
                if (m_press[c]) m_led[c] = ~m_led[c];
            end else begin
                m_led[c] = m_lvl[c];
            end
        end
    endtask

    // ---------------- scoreboard checks ----------------
    task automatic chk(input string tag, input logic [N_CH-1:0] got, input logic [N_CH-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s @%0t: observed %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model steps on the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("state",   STATE,   m_lvl);
        chk("press",   PRESS,   m_press);
        chk("release", RELEASE, m_rel);
        chk("long",    LONG,    m_long);
        chk("led",     LED,     m_led);
    endtask

    // sel: 0 = PRESS, 1 = RELEASE, 2 = LONG. n = ticks taken, -1 on timeout.
    task automatic ticks_until(input logic [N_CH-1:0] mask, input int sel,
                               input int limit, output int n);
        logic [N_CH-1:0] v;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            v = (sel == 0) ? PRESS : (sel == 1) ? RELEASE : LONG;
            if ((v & mask) == mask) begin
                n = i;
                return;
            end
        end
    endtask

    int n;
    int cnt_a, cnt_b;
    logic [2:0] tog_exp;

    initial begin
        model_reset();
        RST  = 1'b1;
        BTN  = '0;
        MODE = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", STATE, '0);
        chk("rst_press", PRESS, '0);
        chk("rst_release", RELEASE, '0);
        chk("rst_long", LONG, '0);
        chk("rst_led", LED, '0);
        RST = 1'b0;
        repeat (3) tick();

        // Clean press and release on ch0, momentary LED.
        BTN = 2'b01;
        ticks_until(2'b01, 0, 20, n);
        chk_int("press_latency", n, 7);
        chk("press_led", LED, 2'b01);
        tick();
        chk("press_one_cycle", PRESS, 2'b00);
        repeat (2) tick();
        BTN = 2'b00;
        ticks_until(2'b01, 1, 20, n);
        chk_int("release_latency", n, 7);
        chk("release_led", LED, 2'b00);
        repeat (3) tick();

        // Bounce on ch0 with 2-cycle periods, then settle high.
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            BTN = (k % 2 == 0) ? 2'b01 : 2'b00;
            repeat (2) begin
                tick();
                if (PRESS[0]) cnt_a++;
            end
        end
        chk_int("bounce_no_press", cnt_a, 0);
        BTN = 2'b01;
        ticks_until(2'b01, 0, 20, n);
        chk_int("bounce_press_latency", n, 7);
        BTN = 2'b00;
        ticks_until(2'b01, 1, 20, n);
        repeat (2) tick();

        // Toggle mode on ch1: LED goes 1,0,1 across three presses.
        MODE = 2'b10;
        tick();
        tog_exp = 3'b101;
        for (int k = 0; k < 3; k++) begin
            BTN = 2'b10;
            ticks_until(2'b10, 0, 20, n);
            chk_int("toggle_press_seen", n, 7);
            chk("toggle_led_on_press", {tog_exp[k], 1'b0}, LED);
            BTN = 2'b00;
            ticks_until(2'b10, 1, 20, n);
            chk("toggle_led_on_release", {tog_exp[k], 1'b0}, LED);
            repeat (2) tick();
        end

        // Long press on ch0 with a short release glitch after LONG.
        BTN = 2'b01;
        ticks_until(2'b01, 0, 20, n);
        ticks_until(2'b01, 2, 30, n);
        chk_int("long_latency", n, LNG);
        repeat (3) tick();
        BTN = 2'b00;
        repeat (2) tick();
        BTN = 2'b01;
        cnt_a = 0;
        cnt_b = 0;
        repeat (20) begin
            tick();
            if (LONG[0]) cnt_a++;
            if (RELEASE[0]) cnt_b++;
        end
        chk_int("glitch_no_second_long", cnt_a, 0);
        chk_int("glitch_no_release", cnt_b, 0);
        BTN = 2'b00;
        ticks_until(2'b01, 1, 20, n);
        chk_int("long_release_latency", n, 7);
        repeat (2) tick();

        // Simultaneous press, then reset while held.
        BTN = 2'b11;
        ticks_until(2'b11, 0, 20, n);
        chk_int("simul_latency", n, 7);
        chk("simul_press", PRESS, 2'b11);
        repeat (3) tick();
        RST = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_state", STATE, '0);
        chk("rst_mid_led", LED, '0);
        chk("rst_mid_pulses", PRESS | RELEASE | LONG, '0);
        @(posedge CLK);
        #1;
        chk("rst_hold_state", STATE, '0);
        chk("rst_hold_pulses", PRESS | RELEASE | LONG, '0);
        RST = 1'b0;
        ticks_until(2'b11, 0, 20, n);
        chk_int("post_rst_press_latency", n, 7);
        chk("post_rst_press", PRESS, 2'b11);
        BTN = 2'b00;
        ticks_until(2'b11, 1, 20, n);
        chk_int("simul_release_latency", n, 7);
        repeat (2) tick();

        // Mode switch on ch0: toggle LED on, then back to momentary.
        MODE = 2'b01;
        tick();
        BTN = 2'b01;
        ticks_until(2'b01, 0, 20, n);
        chk("mode_toggle_led_on", LED, 2'b01);
        BTN = 2'b00;
        ticks_until(2'b01, 1, 20, n);
        tick();
        chk("mode_toggle_led_kept", LED, 2'b01);
        MODE = 2'b00;
        tick();
        chk("mode_switch_led_off", LED, 2'b00);
        repeat (2) tick();

        // Random activity against the model.
        for (int seg = 0; seg < 120; seg++) begin
            BTN = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            if ($urandom_range(0, 7) == 0) MODE = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            repeat ($urandom_range(1, 16)) tick();
        end
        BTN = '0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
